// File: rtl/muldiv_if.sv
// muldiv_if: operation/operand bundle between the datapath and muldiv_unit.
//   aluCtr   - operation code (1101 mult, 1000 div, 0100 mfhi, 0101 mflo)
//   srcA     - rs value (multiplicand / dividend)
//   srcB     - rt value (multiplier / divisor)
//   hi, lo   - architectural HI/LO registers
//   mdResult - HI/LO read-back for mfhi/mflo, 0 otherwise
//   stall    - holds PC and register write enable while an op runs
// master: datapath side; slave: muldiv_unit side.
interface muldiv_if;
  logic [3:0]  aluCtr;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdResult;
  logic        stall;

  modport master (
    output aluCtr, srcA, srcB,
    input  hi, lo, mdResult, stall
  );

  modport slave (
    input  aluCtr, srcA, srcB,
    output hi, lo, mdResult, stall
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed 32x32 multiply / 32/32 divide with HI/LO.
//   clk  - datapath clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - muldiv_if.slave (aluCtr, srcA, srcB in; hi, lo, mdResult, stall out)
// Both operations work on operand magnitudes for 32 cycles and apply the
// sign correction on the final iteration.
// Build option: define MULDIV_FAST_MULT_EN to compute mult in one cycle on
// the issue edge (IDLE -> DONE); div stays iterative.
//
// state | meaning
// IDLE  | waiting for mult/div; stall raised combinationally on issue
// RUN   | one iteration per cycle, counter 0..31
// DONE  | result visible, one cycle guard so the same instruction cannot re-issue
module muldiv_unit (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] OP_MULT = 4'b1101;
  localparam logic [3:0] OP_DIV  = 4'b1000;
  localparam logic [3:0] OP_MFHI = 4'b0100;
  localparam logic [3:0] OP_MFLO = 4'b0101;

  state_t      state;
  logic [5:0]  cnt;
  logic [63:0] acc;      // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [31:0] opb;      // mult: multiplicand magnitude; div: divisor magnitude
  logic        sign_a;
  logic        sign_b;
  logic        op_mult;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic        is_mult;
  logic        is_div;
  logic        start;
  logic        fast_hit;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  assign is_mult = (bus.aluCtr == OP_MULT);
  assign is_div  = (bus.aluCtr == OP_DIV);
  assign start   = (is_mult || is_div) && (state == IDLE);
  assign mag_a   = bus.srcA[31] ? (~bus.srcA + 32'd1) : bus.srcA;
  assign mag_b   = bus.srcB[31] ? (~bus.srcB + 32'd1) : bus.srcB;

`ifdef MULDIV_FAST_MULT_EN
  logic [63:0] fast_prod;
  // Sign-extended operands: the low 64 bits of the product are the signed result.
  assign fast_prod = {{32{bus.srcA[31]}}, bus.srcA} * {{32{bus.srcB[31]}}, bus.srcB};
  assign fast_hit  = is_mult;
`else
  assign fast_hit  = 1'b0;
`endif

  // One iteration of either algorithm.
  logic [32:0] mult_sum;
  logic [63:0] mult_next;
  logic [32:0] div_shift;
  logic [31:0] div_sub;
  logic [63:0] div_next;
  logic [63:0] step_next;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic        div_zero;

  always_comb begin
    mult_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    mult_next = {mult_sum, acc[31:1]};

    // Shifted remainder can reach 33 bits; the subtraction result always fits in 32.
    div_shift = {acc[63:32], acc[31]};
    div_sub   = div_shift[31:0] - opb;
    if (div_shift >= {1'b0, opb})
      div_next = {div_sub, acc[30:0], 1'b1};
    else
      div_next = {div_shift[31:0], acc[30:0], 1'b0};

    step_next = op_mult ? mult_next : div_next;

    prod_fix = (sign_a ^ sign_b) ? (~step_next + 64'd1) : step_next;
    div_zero = (opb == 32'd0);
    // A zero divisor yields an all-ones quotient regardless of signs; the
    // remainder path already reconstructs srcA.
    if (div_zero)
      quo_fix = 32'hFFFF_FFFF;
    else if (sign_a ^ sign_b)
      quo_fix = ~step_next[31:0] + 32'd1;
    else
      quo_fix = step_next[31:0];
    rem_fix = sign_a ? (~step_next[63:32] + 32'd1) : step_next[63:32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 6'd0;
      acc     <= 64'd0;
      opb     <= 32'd0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      op_mult <= 1'b0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
`ifdef MULDIV_FAST_MULT_EN
            if (fast_hit) begin
              hi_r  <= fast_prod[63:32];
              lo_r  <= fast_prod[31:0];
              state <= DONE;
            end else begin
`endif
              sign_a  <= bus.srcA[31];
              sign_b  <= bus.srcB[31];
              op_mult <= is_mult;
              cnt     <= 6'd0;
              if (is_mult) begin
                acc <= {32'd0, mag_b};
                opb <= mag_a;
              end else begin
                acc <= {32'd0, mag_a};
                opb <= mag_b;
              end
              state <= RUN;
`ifdef MULDIV_FAST_MULT_EN
            end
`endif
          end
        end
        RUN: begin
          acc <= step_next;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            if (op_mult) begin
              hi_r <= prod_fix[63:32];
              lo_r <= prod_fix[31:0];
            end else begin
              hi_r <= rem_fix;
              lo_r <= quo_fix;
            end
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;
  // fast_hit is only meaningful on the issue cycle; iterative ops keep stall through RUN.
  assign bus.stall = !rst && (((state == IDLE) && start && (fast_hit || 1'b1)) || (state == RUN));

  always_comb begin
    case (bus.aluCtr)
      OP_MFHI: bus.mdResult = hi_r;
      OP_MFLO: bus.mdResult = lo_r;
      default: bus.mdResult = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random mult/div checks against an arithmetic
// reference model (64-bit signed multiply, truncating signed divide/modulo).
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  muldiv_if bus ();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: returns {HI, LO}.
  function automatic logic [63:0] ref_md(input logic m, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (m) begin
      p   = sa * sb;
      res = p;
    end else if (b == 32'd0) begin
      res = {a, 32'hFFFF_FFFF};
    end else begin
      q   = sa / sb;
      r   = sa % sb;
      res = {r[31:0], q[31:0]};
    end
    return res;
  endfunction

  function automatic int exp_stall(input logic m);
`ifdef MULDIV_FAST_MULT_EN
    return m ? 1 : 33;
`else
    return 33;
`endif
  endfunction

  task automatic run_op(input logic m, input logic [31:0] a, input logic [31:0] b, input logic hold);
    int n;
    logic [63:0] e;
    e = ref_md(m, a, b);
    @(posedge clk); #1;
    bus.aluCtr = m ? 4'b1101 : 4'b1000;
    bus.srcA   = a;
    bus.srcB   = b;
    n = 0;
    @(negedge clk);
    while (bus.stall && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk(m ? "mult_stall_cycles" : "div_stall_cycles", 64'(n), 64'(exp_stall(m)));
    chk("hi", {32'd0, bus.hi}, {32'd0, e[63:32]});
    chk("lo", {32'd0, bus.lo}, {32'd0, e[31:0]});
    if (hold) begin
      // Keep the op code through DONE with different operands; a re-issue would
      // either stall or overwrite HI/LO.
      bus.srcA = ~a;
      bus.srcB = b + 32'd1;
      @(posedge clk); #1;
      bus.aluCtr = 4'b0000;
      repeat (3) begin
        @(negedge clk);
        chk("hold_no_reissue_stall", {63'd0, bus.stall}, 64'd0);
      end
      chk("hold_hi", {32'd0, bus.hi}, {32'd0, e[63:32]});
      chk("hold_lo", {32'd0, bus.lo}, {32'd0, e[31:0]});
    end else begin
      bus.aluCtr = 4'b0000;
    end
    @(negedge clk);
    bus.aluCtr = 4'b0100;
    #1 chk("mfhi", {32'd0, bus.mdResult}, {32'd0, e[63:32]});
    bus.aluCtr = 4'b0101;
    #1 chk("mflo", {32'd0, bus.mdResult}, {32'd0, e[31:0]});
    bus.aluCtr = 4'b0000;
    #1 chk("nop_mdresult", {32'd0, bus.mdResult}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic        m;

    bus.aluCtr = 4'b1101;
    bus.srcA   = 32'd7;
    bus.srcB   = 32'd3;
    #2;
    chk("rst_stall", {63'd0, bus.stall}, 64'd0);
    chk("rst_hi", {32'd0, bus.hi}, 64'd0);
    chk("rst_lo", {32'd0, bus.lo}, 64'd0);
    bus.aluCtr = 4'b0100;
    #1 chk("rst_mfhi", {32'd0, bus.mdResult}, 64'd0);
    @(negedge clk);
    rst        = 1'b0;
    bus.aluCtr = 4'b0101;
    #1 chk("post_rst_mflo", {32'd0, bus.mdResult}, 64'd0);
    bus.aluCtr = 4'b0000;

    run_op(1'b1, 32'd7, 32'hFFFF_FFFD, 1'b0);
    run_op(1'b0, 32'd17, 32'hFFFF_FFFB, 1'b0);
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b0, 32'h0000_0064, 32'd0, 1'b0);
    run_op(1'b0, 32'hFFFF_FF9C, 32'd0, 1'b0);
    run_op(1'b1, 32'h0001_0000, 32'h0001_0000, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(1'b0, 32'hFFFF_FFEF, 32'd5, 1'b0);

    // Reset in the middle of a divide.
    @(posedge clk); #1;
    bus.aluCtr = 4'b1000;
    bus.srcA   = 32'd1000;
    bus.srcB   = 32'd7;
    repeat (11) @(negedge clk);
    chk("mid_run_stall", {63'd0, bus.stall}, 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", {63'd0, bus.stall}, 64'd0);
    chk("mid_rst_hi", {32'd0, bus.hi}, 64'd0);
    chk("mid_rst_lo", {32'd0, bus.lo}, 64'd0);
    @(negedge clk);
    rst        = 1'b0;
    bus.aluCtr = 4'b0000;
    run_op(1'b1, 32'd3, 32'd4, 1'b0);

    run_op(1'b1, 32'h1234_5678, 32'hFFFF_0001, 1'b1);

    for (int i = 0; i < 24; i++) begin
      m = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if (i % 5 == 0) b = 32'($urandom_range(0, 3));
      if (i % 7 == 0) a = 32'h8000_0000;
      if (i % 4 == 1) b = -32'($urandom_range(1, 9));
      run_op(m, a, b, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
